// File: rtl/exec_unit_if.sv
// exec_unit_if: decoder-side issue handshake and write-back result bus of the execute stage
interface exec_unit_if #(
  parameter int DATA_W = 8,
  parameter int OP_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        process_type;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] b;
  logic [DATA_W-1:0] mov_data;
  logic [7:0]        psw;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] ans;
  logic [DATA_W-1:0] b_out;
  logic [7:0]        psw_out;
  logic              busy;
  modport master (
    output in_valid, process_type, alu_op, acc, b, mov_data, psw, out_ready,
    input  in_ready, out_valid, ans, b_out, psw_out, busy
  );
  modport slave (
    input  in_valid, process_type, alu_op, acc, b, mov_data, psw, out_ready,
    output in_ready, out_valid, ans, b_out, psw_out, busy
  );
endinterface

// File: rtl/exec_unit.sv
// exec_unit: execute stage FSM with single-cycle ALU/MOV/pass-through and optional iterative MUL/DIV (EXEC_MULDIV_EN)
module exec_unit #(
  parameter int DATA_W = 8,
  parameter int OP_W = 5
) (
  input logic        clk,
  input logic        rst_n,
  exec_unit_if.slave bus
);
  localparam int W = DATA_W;
  localparam int H = DATA_W / 2;
  localparam logic [1:0] PT_ALU = 2'b01;
  localparam logic [1:0] PT_MOV = 2'b10;
  localparam logic [OP_W-1:0] OP_ADD  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_ADDC = OP_W'(1);
  localparam logic [OP_W-1:0] OP_SUBB = OP_W'(2);
  localparam logic [OP_W-1:0] OP_INC  = OP_W'(3);
  localparam logic [OP_W-1:0] OP_DEC  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_ANL  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_ORL  = OP_W'(6);
  localparam logic [OP_W-1:0] OP_XRL  = OP_W'(7);
  localparam logic [OP_W-1:0] OP_CPL  = OP_W'(8);
  localparam logic [OP_W-1:0] OP_CLR  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_RL   = OP_W'(10);
  localparam logic [OP_W-1:0] OP_RR   = OP_W'(11);
  localparam logic [OP_W-1:0] OP_RLC  = OP_W'(12);
  localparam logic [OP_W-1:0] OP_RRC  = OP_W'(13);
  localparam logic [OP_W-1:0] OP_SWAP = OP_W'(14);
`ifdef EXEC_MULDIV_EN
  localparam logic [OP_W-1:0] OP_MUL  = OP_W'(15);
  localparam logic [OP_W-1:0] OP_DIV  = OP_W'(16);
  localparam int CW = $clog2(DATA_W);
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2, MULDIV = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
`endif

  state_t          state_q, state_d;
  logic [1:0]      pt_q, pt_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    mov_q, mov_d;
  logic [7:1]      psw_q, psw_d;
  logic [W-1:0]    ans_q, ans_d;
  logic [W-1:0]    bo_q, bo_d;
  logic [7:0]      pso_q, pso_d;

  logic         cin;
  logic [W:0]   add_s, sub_s;
  logic [4:0]   add_n, sub_n;
  logic [W-1:0] res_ans;
  logic         res_cy, res_ac, res_ov;

`ifdef EXEC_MULDIV_EN
  logic [W-1:0]  hi_q, hi_d;
  logic [W-1:0]  lo_q, lo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mdiv_q, mdiv_d;
  logic          go_md;
  logic [W:0]    mul_sum, dv_trial, dv_diff;
  logic [W-1:0]  step_hi, step_lo;
`endif

  // single-cycle result and flags from the latched instruction
  always_comb begin
    cin = (op_q == OP_ADD) ? 1'b0 : psw_q[7];
    add_s = {1'b0, acc_q} + {1'b0, b_q} + (W+1)'(cin);
    sub_s = {1'b0, acc_q} - {1'b0, b_q} - (W+1)'(cin);
    add_n = {1'b0, acc_q[3:0]} + {1'b0, b_q[3:0]} + 5'(cin);
    sub_n = {1'b0, acc_q[3:0]} - {1'b0, b_q[3:0]} - 5'(cin);
    res_ans = (pt_q == PT_MOV) ? mov_q : acc_q;
    res_cy = psw_q[7];
    res_ac = psw_q[6];
    res_ov = psw_q[2];
`ifdef EXEC_MULDIV_EN
    go_md = 1'b0;
`endif
    if (pt_q == PT_ALU) begin
      case (op_q)
        OP_ADD, OP_ADDC: begin
          res_ans = add_s[W-1:0];
          res_cy = add_s[W];
          res_ac = add_n[4];
          res_ov = (acc_q[W-1] == b_q[W-1]) && (add_s[W-1] != acc_q[W-1]);
        end
        OP_SUBB: begin
          res_ans = sub_s[W-1:0];
          res_cy = sub_s[W];
          res_ac = sub_n[4];
          res_ov = (acc_q[W-1] != b_q[W-1]) && (sub_s[W-1] != acc_q[W-1]);
        end
        OP_INC:  res_ans = acc_q + W'(1);
        OP_DEC:  res_ans = acc_q - W'(1);
        OP_ANL:  res_ans = acc_q & b_q;
        OP_ORL:  res_ans = acc_q | b_q;
        OP_XRL:  res_ans = acc_q ^ b_q;
        OP_CPL:  res_ans = ~acc_q;
        OP_CLR:  res_ans = '0;
        OP_RL:   res_ans = {acc_q[W-2:0], acc_q[W-1]};
        OP_RR:   res_ans = {acc_q[0], acc_q[W-1:1]};
        OP_RLC: begin
          res_ans = {acc_q[W-2:0], psw_q[7]};
          res_cy = acc_q[W-1];
        end
        OP_RRC: begin
          res_ans = {psw_q[7], acc_q[W-1:1]};
          res_cy = acc_q[0];
        end
        OP_SWAP: res_ans = (acc_q << H) | (acc_q >> (W - H));
`ifdef EXEC_MULDIV_EN
        OP_MUL:  go_md = 1'b1;
        OP_DIV: begin
          go_md = (b_q != '0);
          res_cy = (b_q != '0) ? psw_q[7] : 1'b0;
          res_ov = (b_q != '0) ? psw_q[2] : 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

`ifdef EXEC_MULDIV_EN
  // one shift-add multiply or restoring-divide step on the {hi,lo} pair
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    dv_trial = {hi_q, lo_q[W-1]};
    dv_diff = dv_trial - {1'b0, b_q};
    step_hi = mdiv_q ? (dv_diff[W] ? dv_trial[W-1:0] : dv_diff[W-1:0]) : mul_sum[W:1];
    step_lo = mdiv_q ? {lo_q[W-2:0], ~dv_diff[W]} : {mul_sum[0], lo_q[W-1:1]};
  end
`endif

  // next state, operand capture and result registration
  always_comb begin
    state_d = state_q;
    pt_d = pt_q;
    op_d = op_q;
    acc_d = acc_q;
    b_d = b_q;
    mov_d = mov_q;
    psw_d = psw_q;
    ans_d = ans_q;
    bo_d = bo_q;
    pso_d = pso_q;
`ifdef EXEC_MULDIV_EN
    hi_d = hi_q;
    lo_d = lo_q;
    cnt_d = cnt_q;
    mdiv_d = mdiv_q;
`endif
    case (state_q)
      IDLE: if (bus.in_valid) begin
        pt_d = bus.process_type;
        op_d = bus.alu_op;
        acc_d = bus.acc;
        b_d = bus.b;
        mov_d = bus.mov_data;
        psw_d = bus.psw[7:1];
        state_d = CALC;
      end
      CALC: begin
`ifdef EXEC_MULDIV_EN
        if (go_md) begin
          hi_d = '0;
          lo_d = acc_q;
          cnt_d = '0;
          mdiv_d = (op_q == OP_DIV);
          state_d = MULDIV;
        end else
`endif
        begin
          ans_d = res_ans;
          bo_d = b_q;
          pso_d = {res_cy, res_ac, psw_q[5:3], res_ov, psw_q[1], ^res_ans};
          state_d = DONE;
        end
      end
`ifdef EXEC_MULDIV_EN
      MULDIV: begin
        hi_d = step_hi;
        lo_d = step_lo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          cnt_d = '0;
          ans_d = step_lo;
          bo_d = step_hi;
          pso_d = {1'b0, psw_q[6], psw_q[5:3], ~mdiv_q & (|step_hi), psw_q[1], ^step_lo};
          state_d = DONE;
        end
      end
`endif
      DONE: state_d = bus.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pt_q <= '0;
      op_q <= '0;
      acc_q <= '0;
      b_q <= '0;
      mov_q <= '0;
      psw_q <= '0;
      ans_q <= '0;
      bo_q <= '0;
      pso_q <= '0;
`ifdef EXEC_MULDIV_EN
      hi_q <= '0;
      lo_q <= '0;
      cnt_q <= '0;
      mdiv_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pt_q <= pt_d;
      op_q <= op_d;
      acc_q <= acc_d;
      b_q <= b_d;
      mov_q <= mov_d;
      psw_q <= psw_d;
      ans_q <= ans_d;
      bo_q <= bo_d;
      pso_q <= pso_d;
`ifdef EXEC_MULDIV_EN
      hi_q <= hi_d;
      lo_q <= lo_d;
      cnt_q <= cnt_d;
      mdiv_q <= mdiv_d;
`endif
    end
  end

  assign bus.in_ready = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy = (state_q != IDLE);
  assign bus.ans = ans_q;
  assign bus.b_out = bo_q;
  assign bus.psw_out = pso_q;
endmodule
